pcileech_rst_ctl: RTL and testbench
===================================

// Module: pcileech_rst_ctl
// PURPOSE
//  Reset and board-signal conditioning stage upstream of the com/fifo/pcie cores on the FPGA top.
//  Generates the power-on system reset (rst, active-high) and the FT601 reset.
//  Synchronises and debounces PCIe PERST#/PRSNT#, exports the free-running tickcount64 and the power-on LED blink.
//  Optionally drives PCIe WAKE#.
// PARAMETERS
//  POR_CYCLES        64    clk cycles rst is held high after reset release
//  DEBOUNCE_CYCLES   1000  consecutive stable cycles before a debounced input deasserts/asserts high
//  BLINK_BIT         24    tickcount bit driving the LED blink
//  BLINK_WINDOW_BIT  27    blink enabled only while tickcount[63:BLINK_WINDOW_BIT]==0
//  WAKE_PULSE_CYCLES 10000 WAKE# low-pulse length in clk cycles
// PORTS
//  clk                in   1   system clock (100 MHz)
//  rst_n              in   1   asynchronous, active-low reset
//  pcie_perst_n_in    in   1   raw PERST# pad (async)
//  pcie_present_in    in   1   raw PRSNT pad (async)
//  wake_req           in   1   request to signal WAKE# (level; rising edge sampled)
//  rst                out  1   synchronous active-high system reset to com/fifo/pcie
//  ft601_rst_n        out  1   FT601 reset, equals ~rst
//  pcie_perst_n_sync  out  1   synchronised/debounced PERST#
//  pcie_present_sync  out  1   synchronised/debounced PRSNT
//  led_pwronblink     out  1   power-on blink for com LED invert
//  pcie_wake_n        out  1   PCIe WAKE#, open-drain style active-low
//  tickcount64        out  64  free-running cycle counter
// BEHAVIOUR
//  - rst_n feeds a 2-flop reset synchroniser: async assert, release on 2nd clk edge. All state below is reset by its output.
//  - Reset values: rst=1, ft601_rst_n=0, tickcount64=0, pcie_perst_n_sync=0, pcie_present_sync=0, led_pwronblink=0, pcie_wake_n=1.
//  - tickcount64 increments every cycle after synchroniser release and wraps 2^64-1 -> 0.
//  - FSM {S_POR, S_RUN}:
//    - S_POR: rst=1.
//    - S_POR -> S_RUN on the edge where tickcount64 reaches POR_CYCLES. rst=0 from that edge.
//    - S_RUN is sticky. Only rst_n returns to S_POR; tickcount64 wrap does not.
//  - Reset mid-operation: rst_n low forces S_POR and rst=1 within the same cycle (async). Any WAKE# pulse aborts and pcie_wake_n=1.
//  - Input conditioning, per input:
//    - 2-flop synchroniser, then stability counter.
//    - Falling (assert for PERST#) propagates immediately after the synchroniser: 2-cycle latency, counter cleared.
//    - Rising propagates only after DEBOUNCE_CYCLES consecutive high samples. Latency = 2 + DEBOUNCE_CYCLES.
//    - Any low glitch restarts the count. Counter saturates and never wraps.
//  - led_pwronblink is registered: tickcount64[BLINK_BIT] & (tickcount64[63:BLINK_WINDOW_BIT]==0), 1-cycle latency.
// CONFIGURATION
//  - PCILEECH_RST_WAKE_EN defined, in S_RUN:
//    - A rising edge of wake_req while pcie_perst_n_sync==0 drives pcie_wake_n=0 for exactly WAKE_PULSE_CYCLES.
//    - Edges during an active pulse are ignored.
//    - The pulse ends early, on the next cycle, when pcie_perst_n_sync rises.
//    - Edges in S_POR or while pcie_perst_n_sync==1 are ignored.
//  - Not defined: pcie_wake_n tied 1, wake_req unused, no wake logic synthesised.
// STRUCTURE
//  - Package pcileech_rst_pkg holds:
//    - typedef enum logic [0:0] {S_POR, S_RUN} rst_state_t;
//    - localparam SYNC_STAGES = 2.
//  - Sub-module pcileech_sync_debounce #(DEBOUNCE_CYCLES): synchroniser plus asymmetric debounce. Instanced for PERST# and PRSNT.
// TESTING
//  (bench overrides: POR_CYCLES=64, DEBOUNCE_CYCLES=8, WAKE_PULSE_CYCLES=16)
//  1. Release rst_n at t0 -> rst=1 and ft601_rst_n=0 for 2+64 edges, then rst=0. Check tickcount64==64 at that edge.
//  2. PERST# low->high stable -> pcie_perst_n_sync rises 10 cycles later.
//     High with a 1-cycle low glitch at cycle 5 -> rise delayed to 10 cycles after the glitch ends.
//  3. pcie_perst_n_sync=1, drive PERST# low -> pcie_perst_n_sync=0 exactly 2 cycles later.
//  4. Force tickcount64=64'hFFFF_FFFF_FFFF_FFFE in S_RUN -> wraps to 0, rst stays 0.
//     led_pwronblink follows bit 24 only while tickcount64<2^27.
//  5. WAKE_EN, in S_RUN, PERST#=0, wake_req edge -> pcie_wake_n=0 for 16 cycles. A second edge at cycle 4 has no effect.
//     Repeat and raise PERST# mid-pulse -> pcie_wake_n=1 one cycle after the sync rises.
//  6. rst_n low mid-WAKE pulse at cycle 8 -> rst=1 and pcie_wake_n=1 immediately.
//     After release -> full 64-cycle POR repeats.

Source files
------------

// File: rtl/pcileech_rst_pkg.sv
// Shared types and constants for the pcileech reset/conditioning block.
// Imported by pcileech_sync_debounce and pcileech_rst_ctl.
package pcileech_rst_pkg;

  typedef enum logic [0:0] {
    S_POR,
    S_RUN
  } rst_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pcileech_sync_debounce.sv
// Two-flop synchroniser plus asymmetric debounce.
// Low passes straight through; high needs DEBOUNCE_CYCLES stable samples.
module pcileech_sync_debounce
  import pcileech_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // metastability chain for the raw pad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // saturating count of consecutive high samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!s) begin
      cnt_q <= '0;
    end else if (cnt_q != CMAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign dout = s & (cnt_q == CMAX);

endmodule

// File: rtl/pcileech_rst_ctl.sv
// Power-on reset, PERST#/PRSNT conditioning, tick counter and LED blink.
// Optional WAKE# pulse generator enabled by PCILEECH_RST_WAKE_EN.
module pcileech_rst_ctl
  import pcileech_rst_pkg::*;
#(
  parameter int POR_CYCLES        = 64,
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int BLINK_BIT         = 24,
  parameter int BLINK_WINDOW_BIT  = 27,
  parameter int WAKE_PULSE_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcie_perst_n_in,
  input  logic        pcie_present_in,
  input  logic        wake_req,
  output logic        rst,
  output logic        ft601_rst_n,
  output logic        pcie_perst_n_sync,
  output logic        pcie_present_sync,
  output logic        led_pwronblink,
  output logic        pcie_wake_n,
  output logic [63:0] tickcount64
);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   srst_n;
  rst_state_t             state_q;
  rst_state_t             state_d;
  logic [63:0]            tick_q;
  logic                   led_q;

  // async assert, synchronous release of the internal reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign srst_n = rst_sync_q[SYNC_STAGES-1];

  // POR state register
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= S_POR;
    end else begin
      state_q <= state_d;
    end
  end

  // leave POR on the edge the tick reaches POR_CYCLES; RUN is sticky
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_POR: begin
        if (tick_q == 64'(POR_CYCLES - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: state_d = S_RUN;
      default: state_d = S_POR;
    endcase
  end

  assign rst         = (state_q == S_POR);
  assign ft601_rst_n = ~rst;

  // free-running cycle counter
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 64'd1;
    end
  end

  assign tickcount64 = tick_q;

  // blink only during the first window after power-on
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      led_q <= 1'b0;
    end else begin
      led_q <= tick_q[BLINK_BIT] & ~|tick_q[63:BLINK_WINDOW_BIT];
    end
  end

  assign led_pwronblink = led_q;

  pcileech_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_perst (
    .clk  (clk),
    .rst_n(srst_n),
    .din  (pcie_perst_n_in),
    .dout (pcie_perst_n_sync)
  );

  pcileech_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_present (
    .clk  (clk),
    .rst_n(srst_n),
    .din  (pcie_present_in),
    .dout (pcie_present_sync)
  );

`ifdef PCILEECH_RST_WAKE_EN
  localparam int WCW = $clog2(WAKE_PULSE_CYCLES + 1);

  logic           wake_q;
  logic           wake_act_q;
  logic [WCW-1:0] wake_cnt_q;
  logic           wake_edge;

  assign wake_edge = wake_req & ~wake_q;

  // WAKE# pulse: start on request edge while PERST# held, end on timeout or PERST# release
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wake_q     <= 1'b0;
      wake_act_q <= 1'b0;
      wake_cnt_q <= '0;
    end else begin
      wake_q <= wake_req;
      if (wake_act_q) begin
        if (pcie_perst_n_sync || wake_cnt_q == '0) begin
          wake_act_q <= 1'b0;
        end else begin
          wake_cnt_q <= wake_cnt_q - 1'b1;
        end
      end else if (state_q == S_RUN && wake_edge && !pcie_perst_n_sync) begin
        wake_act_q <= 1'b1;
        wake_cnt_q <= WCW'(WAKE_PULSE_CYCLES - 1);
      end
    end
  end

  assign pcie_wake_n = ~wake_act_q;
`else
  logic wake_unused;

  assign wake_unused = wake_req ^ (WAKE_PULSE_CYCLES == 0);
  assign pcie_wake_n = 1'b1;
`endif

endmodule

// File: tb/tb_pcileech_rst_ctl.sv
// Directed bench for pcileech_rst_ctl.
// Wake checks depend on PCILEECH_RST_WAKE_EN.
module tb_pcileech_rst_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcie_perst_n_in = 1'b0;
  logic        pcie_present_in = 1'b0;
  logic        wake_req = 1'b0;
  logic        rst;
  logic        ft601_rst_n;
  logic        pcie_perst_n_sync;
  logic        pcie_present_sync;
  logic        led_pwronblink;
  logic        pcie_wake_n;
  logic [63:0] tickcount64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcileech_rst_ctl #(
    .POR_CYCLES       (64),
    .DEBOUNCE_CYCLES  (8),
    .BLINK_BIT        (24),
    .BLINK_WINDOW_BIT (27),
    .WAKE_PULSE_CYCLES(16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pcie_perst_n_in  (pcie_perst_n_in),
    .pcie_present_in  (pcie_present_in),
    .wake_req         (wake_req),
    .rst              (rst),
    .ft601_rst_n      (ft601_rst_n),
    .pcie_perst_n_sync(pcie_perst_n_sync),
    .pcie_present_sync(pcie_present_sync),
    .led_pwronblink   (led_pwronblink),
    .pcie_wake_n      (pcie_wake_n),
    .tickcount64      (tickcount64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_por(input string tag);
    logic e;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 66; n++) begin
      step();
      e = (n < 66);
      checks++;
      if (rst !== e || ft601_rst_n !== ~e) begin
        errors++;
        $display("FAIL %s_por n=%0d rst=%b ft601_rst_n=%b want rst=%b",
                 tag, n, rst, ft601_rst_n, e);
      end
    end
    checks++;
    if (tickcount64 !== 64'd64) begin
      errors++;
      $display("FAIL %s_tick got=%0d want=64", tag, tickcount64);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rst, ft601_rst_n, pcie_perst_n_sync, pcie_present_sync,
         led_pwronblink, pcie_wake_n} !== 6'b100001 || tickcount64 !== 64'd0) begin
      errors++;
      $display("FAIL reset_vals got=%b%b%b%b%b%b tick=%0d want=100001 tick=0",
               rst, ft601_rst_n, pcie_perst_n_sync, pcie_present_sync,
               led_pwronblink, pcie_wake_n, tickcount64);
    end
    run_por("init");
  endtask

  task automatic test_debounce();
    logic e;
    @(negedge clk);
    pcie_perst_n_in = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      e = (n >= 10);
      checks++;
      if (pcie_perst_n_sync !== e) begin
        errors++;
        $display("FAIL perst_rise n=%0d got=%b want=%b", n, pcie_perst_n_sync, e);
      end
    end
    @(negedge clk);
    pcie_present_in = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      e = (n >= 10);
      checks++;
      if (pcie_present_sync !== e) begin
        errors++;
        $display("FAIL prsnt_rise n=%0d got=%b want=%b", n, pcie_present_sync, e);
      end
    end
    @(negedge clk);
    pcie_perst_n_in = 1'b0;
    repeat (4) step();
    checks++;
    if (pcie_perst_n_sync !== 1'b0) begin
      errors++;
      $display("FAIL perst_low got=%b want=0", pcie_perst_n_sync);
    end
    @(negedge clk);
    pcie_perst_n_in = 1'b1;
    repeat (4) step();
    @(negedge clk);
    pcie_perst_n_in = 1'b0;
    step();
    @(negedge clk);
    pcie_perst_n_in = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      e = (n >= 10);
      checks++;
      if (pcie_perst_n_sync !== e) begin
        errors++;
        $display("FAIL perst_glitch n=%0d got=%b want=%b", n, pcie_perst_n_sync, e);
      end
    end
  endtask

  task automatic test_perst_fall();
    @(negedge clk);
    pcie_perst_n_in = 1'b0;
    step();
    checks++;
    if (pcie_perst_n_sync !== 1'b1) begin
      errors++;
      $display("FAIL perst_fall1 got=%b want=1", pcie_perst_n_sync);
    end
    step();
    checks++;
    if (pcie_perst_n_sync !== 1'b0) begin
      errors++;
      $display("FAIL perst_fall2 got=%b want=0", pcie_perst_n_sync);
    end
  endtask

  task automatic test_wrap_led();
    @(negedge clk);
    force dut.tick_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.tick_q;
    step();
    checks++;
    if (tickcount64 !== 64'hFFFF_FFFF_FFFF_FFFF || rst !== 1'b0) begin
      errors++;
      $display("FAIL wrap_max tick=%h rst=%b want ffffffffffffffff 0", tickcount64, rst);
    end
    step();
    checks++;
    if (tickcount64 !== 64'd0 || rst !== 1'b0 || led_pwronblink !== 1'b0) begin
      errors++;
      $display("FAIL wrap_zero tick=%h rst=%b led=%b want 0 0 0",
               tickcount64, rst, led_pwronblink);
    end
    @(negedge clk);
    force dut.tick_q = 64'h0000_0000_00FF_FFFF;
    #1;
    release dut.tick_q;
    step();
    checks++;
    if (led_pwronblink !== 1'b0) begin
      errors++;
      $display("FAIL led_pre24 got=%b want=0", led_pwronblink);
    end
    step();
    checks++;
    if (led_pwronblink !== 1'b1) begin
      errors++;
      $display("FAIL led_bit24 got=%b want=1", led_pwronblink);
    end
    @(negedge clk);
    force dut.tick_q = 64'h0000_0000_07FF_FFFF;
    #1;
    release dut.tick_q;
    step();
    checks++;
    if (led_pwronblink !== 1'b1) begin
      errors++;
      $display("FAIL led_lastwin got=%b want=1", led_pwronblink);
    end
    step();
    checks++;
    if (led_pwronblink !== 1'b0) begin
      errors++;
      $display("FAIL led_outwin got=%b want=0", led_pwronblink);
    end
    @(negedge clk);
    force dut.tick_q = 64'h0000_0000_0900_0000;
    #1;
    release dut.tick_q;
    step();
    step();
    checks++;
    if (led_pwronblink !== 1'b0) begin
      errors++;
      $display("FAIL led_hiwin got=%b want=0", led_pwronblink);
    end
  endtask

  task automatic test_wake();
    logic e;
`ifdef PCILEECH_RST_WAKE_EN
    @(negedge clk);
    wake_req = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      step();
      e = (n > 16);
      checks++;
      if (pcie_wake_n !== e) begin
        errors++;
        $display("FAIL wake_pulse n=%0d got=%b want=%b", n, pcie_wake_n, e);
      end
      if (n == 2) begin
        @(negedge clk);
        wake_req = 1'b0;
      end
      if (n == 3) begin
        @(negedge clk);
        wake_req = 1'b1;
      end
    end
    @(negedge clk);
    wake_req = 1'b0;
    repeat (2) step();
    @(negedge clk);
    wake_req = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      step();
      e = (n >= 14);
      checks++;
      if (pcie_wake_n !== e || pcie_perst_n_sync !== (n >= 13)) begin
        errors++;
        $display("FAIL wake_abort n=%0d wake_n=%b sync=%b want %b %b",
                 n, pcie_wake_n, pcie_perst_n_sync, e, n >= 13);
      end
      if (n == 3) begin
        @(negedge clk);
        pcie_perst_n_in = 1'b1;
      end
    end
    @(negedge clk);
    wake_req = 1'b0;
    step();
    @(negedge clk);
    wake_req = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step();
      checks++;
      if (pcie_wake_n !== 1'b1) begin
        errors++;
        $display("FAIL wake_ignored n=%0d got=%b want=1", n, pcie_wake_n);
      end
    end
`else
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      wake_req = n[0];
      step();
      e = 1'b1;
      checks++;
      if (pcie_wake_n !== e) begin
        errors++;
        $display("FAIL wake_tied n=%0d got=%b want=1", n, pcie_wake_n);
      end
    end
`endif
    @(negedge clk);
    wake_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    pcie_perst_n_in = 1'b0;
    wake_req = 1'b0;
    repeat (3) step();
`ifdef PCILEECH_RST_WAKE_EN
    @(negedge clk);
    wake_req = 1'b1;
    for (int n = 1; n <= 8; n++) step();
    checks++;
    if (pcie_wake_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_pulse got=%b want=0", pcie_wake_n);
    end
`else
    repeat (8) step();
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rst !== 1'b1 || ft601_rst_n !== 1'b0 || pcie_wake_n !== 1'b1 ||
        tickcount64 !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset rst=%b ft=%b wake_n=%b tick=%0d want 1 0 1 0",
               rst, ft601_rst_n, pcie_wake_n, tickcount64);
    end
    wake_req = 1'b0;
    repeat (2) @(negedge clk);
    run_por("again");
    checks++;
    if (pcie_wake_n !== 1'b1 || pcie_perst_n_sync !== 1'b0) begin
      errors++;
      $display("FAIL post_por wake_n=%b sync=%b want 1 0",
               pcie_wake_n, pcie_perst_n_sync);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_perst_fall();
    test_wrap_led();
    test_wake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
